// File: rtl/push_button_bank.sv
// Multi-channel push-button conditioner: synchroniser, debouncer and
// press / release / long-press / auto-repeat event generator per channel.
module push_button_bank #(
   parameter int N_CH            = 5,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] btn_in,
   input  logic [N_CH-1:0] repeat_en,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] press,
   output logic [N_CH-1:0] released,
   output logic [N_CH-1:0] long_press
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(LONG_CYCLES);
   localparam int RW = $clog2(REPEAT_CYCLES);

   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DOWN = 2'd1;
   localparam logic [1:0] ST_HELD = 2'd2;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [DW-1:0]          deb_cnt;
      logic [HW-1:0]          hold_cnt;
      logic [RW-1:0]          rep_cnt;
      logic [1:0]             state;
      logic                   lvl;
      logic                   prs;
      logic                   rls;
      logic                   lng;
      logic                   s;
      logic                   flip;
      logic                   rise;
      logic                   fall;

      assign s    = sync_q[SYNC_STAGES-1];
      assign flip = (s != lvl) && (deb_cnt == DEB_LAST);
      assign rise = flip & ~lvl;
      assign fall = flip & lvl;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sync_q <= '0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
         end
      end

      // Counter only runs while the synchronised input disagrees.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            deb_cnt <= '0;
            lvl     <= 1'b0;
         end else if (s == lvl) begin
            deb_cnt <= '0;
         end else if (flip) begin
            deb_cnt <= '0;
            lvl     <= ~lvl;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            prs      <= 1'b0;
            rls      <= 1'b0;
            lng      <= 1'b0;
         end else begin
            prs <= 1'b0;
            rls <= 1'b0;
            lng <= 1'b0;
            case (state)
               ST_IDLE: begin
                  if (rise) begin
                     prs      <= 1'b1;
                     state    <= ST_DOWN;
                     hold_cnt <= '0;
                  end
               end
               ST_DOWN: begin
                  if (fall) begin
                     rls      <= 1'b1;
                     state    <= ST_IDLE;
                     hold_cnt <= '0;
                     rep_cnt  <= '0;
                  end else if (hold_cnt == HOLD_LAST) begin
                     lng     <= 1'b1;
                     state   <= ST_HELD;
                     rep_cnt <= '0;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               ST_HELD: begin
                  // A fall on the same cycle as a repeat tick suppresses the tick.
                  if (fall) begin
                     rls      <= 1'b1;
                     state    <= ST_IDLE;
                     hold_cnt <= '0;
                     rep_cnt  <= '0;
                  end else if (!repeat_en[i]) begin
                     rep_cnt <= '0;
                  end else if (rep_cnt == REP_LAST) begin
                     prs     <= 1'b1;
                     rep_cnt <= '0;
                  end else begin
                     rep_cnt <= rep_cnt + 1'b1;
                  end
               end
               default: begin
                  state    <= ST_IDLE;
                  hold_cnt <= '0;
                  rep_cnt  <= '0;
               end
            endcase
         end
      end

      assign level[i]      = lvl;
      assign press[i]      = prs;
      assign released[i]   = rls;
      assign long_press[i] = lng;
   end

endmodule

// File: tb/tb_push_button_bank.sv
// Bench for push_button_bank: timestamp-based event model plus
// directed timing checks for each scenario.
module tb_push_button_bank;
   localparam int N_CH = 4;
   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int LONG = 10;
   localparam int REP  = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N_CH-1:0] btn_in = '0;
   logic [N_CH-1:0] repeat_en = '0;
   logic [N_CH-1:0] level;
   logic [N_CH-1:0] press;
   logic [N_CH-1:0] released;
   logic [N_CH-1:0] long_press;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   push_button_bank #(
      .N_CH(N_CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
      .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
   ) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in), .repeat_en(repeat_en),
      .level(level), .press(press), .released(released),
      .long_press(long_press)
   );

   // Reference model: delayed samples, run length of disagreement,
   // and time elapsed since the press.
   logic [N_CH-1:0] m_hist [SYNC];
   logic [N_CH-1:0] e_level, e_press, e_rel, e_long;
   int m_run [N_CH];
   int m_age [N_CH];
   int m_rep [N_CH];
   bit m_down [N_CH];
   bit m_longed [N_CH];

   always @(posedge clk or negedge rst) begin : model
      logic [N_CH-1:0] s, lv, pr, rl, lg;
      int run [N_CH];
      int age [N_CH];
      int rep [N_CH];
      bit dn [N_CH];
      bit lgd [N_CH];
      bit rise, fall;
      if (!rst) begin
         for (int k = 0; k < SYNC; k++) m_hist[k] <= '0;
         for (int i = 0; i < N_CH; i++) begin
            m_run[i] <= 0; m_age[i] <= 0; m_rep[i] <= 0;
            m_down[i] <= 0; m_longed[i] <= 0;
         end
         e_level <= '0; e_press <= '0; e_rel <= '0; e_long <= '0;
      end else begin
         s  = m_hist[SYNC-1];
         lv = e_level;
         pr = '0; rl = '0; lg = '0;
         for (int i = 0; i < N_CH; i++) begin
            run[i] = m_run[i]; age[i] = m_age[i]; rep[i] = m_rep[i];
            dn[i] = m_down[i]; lgd[i] = m_longed[i];
            rise = 0; fall = 0;
            if (s[i] == lv[i]) run[i] = 0;
            else begin
               run[i]++;
               if (run[i] == DEB) begin
                  lv[i] = ~lv[i]; run[i] = 0;
                  rise = lv[i]; fall = !lv[i];
               end
            end
            if (fall) begin
               rl[i] = 1; dn[i] = 0; lgd[i] = 0;
            end else if (rise) begin
               pr[i] = 1; dn[i] = 1; age[i] = 0; lgd[i] = 0;
            end else if (dn[i]) begin
               age[i]++;
               if (!lgd[i] && age[i] == LONG) begin
                  lg[i] = 1; lgd[i] = 1; rep[i] = 0;
               end else if (lgd[i]) begin
                  if (!repeat_en[i]) rep[i] = 0;
                  else begin
                     rep[i]++;
                     if (rep[i] == REP) begin pr[i] = 1; rep[i] = 0; end
                  end
               end
            end
            m_run[i] <= run[i]; m_age[i] <= age[i]; m_rep[i] <= rep[i];
            m_down[i] <= dn[i]; m_longed[i] <= lgd[i];
         end
         m_hist[0] <= btn_in;
         for (int k = 1; k < SYNC; k++) m_hist[k] <= m_hist[k-1];
         e_level <= lv; e_press <= pr; e_rel <= rl; e_long <= lg;
      end
   end

   task automatic test_reset();
      int rise_at = -1;
      rst = 1'b0; btn_in = '0; repeat_en = '0;
      #7;
      n_total++;
      if ({level, press, released, long_press} !== 16'h0)
         $display("FAIL reset_init got=%h want=0",
                  {level, press, released, long_press});
      else n_pass++;
      @(negedge clk) rst = 1'b1;
      btn_in = 4'hF;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         n_total++;
         if ({level, press, released, long_press} !==
             {e_level, e_press, e_rel, e_long})
            $display("FAIL reset_model c=%0d got=%h want=%h", c,
                     {level, press, released, long_press},
                     {e_level, e_press, e_rel, e_long});
         else n_pass++;
      end
      @(posedge clk); #3 rst = 1'b0; #1;
      n_total++;
      if ({level, press, released, long_press} !== 16'h0)
         $display("FAIL reset_async got=%h want=0",
                  {level, press, released, long_press});
      else n_pass++;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         n_total++;
         if ({level, press, released, long_press} !==
             {e_level, e_press, e_rel, e_long})
            $display("FAIL reset_model2 c=%0d got=%h want=%h", c,
                     {level, press, released, long_press},
                     {e_level, e_press, e_rel, e_long});
         else n_pass++;
         if (rise_at < 0 && level == 4'hF) begin
            rise_at = c;
            n_total++;
            if (press !== 4'hF)
               $display("FAIL reset_press got=%h want=f", press);
            else n_pass++;
         end
         if (c == 12) btn_in = '0;
      end
      n_total++;
      if (rise_at != SYNC + DEB)
         $display("FAIL reset_latency got=%0d want=%0d", rise_at, SYNC + DEB);
      else n_pass++;
   endtask

   task automatic test_bounce();
      int n_bp = 0, n_sp = 0, n_sr = 0, rise_at = -1;
      btn_in = '0; repeat_en = '0;
      for (int k = 1; k <= 3; k++) begin
         int gap = $urandom_range(2, 4);
         for (int j = 0; j < k + gap; j++) begin
            btn_in[0] = (j < k);
            @(posedge clk); #1;
            n_total++;
            if ({level, press, released, long_press} !==
                {e_level, e_press, e_rel, e_long})
               $display("FAIL bounce_model k=%0d got=%h want=%h", k,
                        {level, press, released, long_press},
                        {e_level, e_press, e_rel, e_long});
            else n_pass++;
            n_bp += press[0];
         end
      end
      btn_in[0] = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         @(posedge clk); #1;
         n_total++;
         if ({level, press, released, long_press} !==
             {e_level, e_press, e_rel, e_long})
            $display("FAIL bounce_model2 c=%0d got=%h want=%h", c,
                     {level, press, released, long_press},
                     {e_level, e_press, e_rel, e_long});
         else n_pass++;
         if (rise_at < 0 && level[0]) rise_at = c;
         n_sp += press[0];
         if (c <= 8) n_sr += released[0];
         if (c == 8) btn_in[0] = 1'b0;
      end
      n_total++;
      if (n_bp != 0) $display("FAIL bounce_nopress got=%0d want=0", n_bp);
      else n_pass++;
      n_total++;
      if (rise_at != SYNC + DEB)
         $display("FAIL bounce_latency got=%0d want=%0d", rise_at, SYNC + DEB);
      else n_pass++;
      n_total++;
      if (n_sp != 1 || n_sr != 0)
         $display("FAIL bounce_pulses got=%0d/%0d want=1/0", n_sp, n_sr);
      else n_pass++;
   endtask

   task automatic test_long_repeat();
      int p = -1, long_at = -1, n_long = 0, n_rep = 0, first_rep = -1;
      int rel_at = -1, n_rel = 0, fall_c = -1;
      repeat_en = 4'b0010; btn_in = 4'b0010;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk); #1;
         n_total++;
         if ({level, press, released, long_press} !==
             {e_level, e_press, e_rel, e_long})
            $display("FAIL long_model c=%0d got=%h want=%h", c,
                     {level, press, released, long_press},
                     {e_level, e_press, e_rel, e_long});
         else n_pass++;
         if (press[1]) begin
            if (p < 0) p = c;
            else begin
               n_rep++;
               if (first_rep < 0) first_rep = c;
            end
         end
         if (long_press[1]) begin n_long++; long_at = c; end
         if (released[1]) begin n_rel++; rel_at = c; end
         if (p > 0 && c == p + 30) begin btn_in[1] = 1'b0; fall_c = c; end
      end
      repeat_en = '0;
      n_total++;
      if (n_long != 1 || long_at - p != LONG)
         $display("FAIL long_once got=%0d@%0d want=1@%0d", n_long,
                  long_at - p, LONG);
      else n_pass++;
      n_total++;
      if (first_rep - long_at != REP || n_rep != (30 + SYNC + DEB - LONG - 1) / REP)
         $display("FAIL long_repeat got=%0d/%0d want=%0d/%0d",
                  first_rep - long_at, n_rep, REP,
                  (30 + SYNC + DEB - LONG - 1) / REP);
      else n_pass++;
      n_total++;
      if (n_rel != 1 || rel_at - fall_c != SYNC + DEB)
         $display("FAIL long_release got=%0d@%0d want=1@%0d", n_rel,
                  rel_at - fall_c, SYNC + DEB);
      else n_pass++;
   endtask

   task automatic test_repeat_toggle();
      int p = -1, long_at = -1, n_long = 0, en_c = -1;
      int n_early = 0, first_rep = -1;
      repeat_en = '0; btn_in = 4'b0100;
      for (int c = 1; c <= 50; c++) begin
         @(posedge clk); #1;
         n_total++;
         if ({level, press, released, long_press} !==
             {e_level, e_press, e_rel, e_long})
            $display("FAIL rtog_model c=%0d got=%h want=%h", c,
                     {level, press, released, long_press},
                     {e_level, e_press, e_rel, e_long});
         else n_pass++;
         if (press[2]) begin
            if (p < 0) p = c;
            else if (en_c < 0) n_early++;
            else if (first_rep < 0) first_rep = c;
         end
         if (long_press[2]) begin n_long++; long_at = c; end
         if (long_at > 0 && en_c < 0 && c == long_at + 5) begin
            repeat_en[2] = 1'b1; en_c = c;
         end
         if (p > 0 && c == p + 24) btn_in[2] = 1'b0;
      end
      repeat_en = '0;
      n_total++;
      if (n_long != 1 || n_early != 0)
         $display("FAIL rtog_norepeat got=%0d/%0d want=1/0", n_long, n_early);
      else n_pass++;
      n_total++;
      if (first_rep - en_c != REP)
         $display("FAIL rtog_first got=%0d want=%0d", first_rep - en_c, REP);
      else n_pass++;
   endtask

   task automatic test_independent();
      int n_p0 = 0, n_r0 = 0, n_p3 = 0, n_r3 = 0, other = 0;
      btn_in = '0; repeat_en = '0;
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1 btn_in = 4'b1001;
      for (int c = 1; c <= 24; c++) begin
         @(posedge clk); #1;
         n_total++;
         if ({level, press, released, long_press} !==
             {e_level, e_press, e_rel, e_long})
            $display("FAIL indep_model c=%0d got=%h want=%h", c,
                     {level, press, released, long_press},
                     {e_level, e_press, e_rel, e_long});
         else n_pass++;
         n_p0 += press[0]; n_r0 += released[0];
         n_p3 += press[3]; n_r3 += released[3];
         other += int'(|{level[2:0], press[2:1], released[2:1], long_press});
         if (c == 3) btn_in[0] = 1'b0;
         if (c == 8) btn_in[3] = 1'b0;
      end
      n_total++;
      if (n_p0 != 0 || n_r0 != 0)
         $display("FAIL indep_ch0 got=%0d/%0d want=0/0", n_p0, n_r0);
      else n_pass++;
      n_total++;
      if (n_p3 != 1 || n_r3 != 1 || other != 0)
         $display("FAIL indep_ch3 got=%0d/%0d/%0d want=1/1/0", n_p3, n_r3, other);
      else n_pass++;
   endtask

   task automatic test_collision();
      int p = -1, n_long = 0, n_rel = 0, rel_at = -1;
      int p2 = -1, long2 = -1;
      repeat_en = '0; repeat_en[1] = 1'($urandom_range(0, 1));
      btn_in = 4'b0010;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk); #1;
         n_total++;
         if ({level, press, released, long_press} !==
             {e_level, e_press, e_rel, e_long})
            $display("FAIL coll_model c=%0d got=%h want=%h", c,
                     {level, press, released, long_press},
                     {e_level, e_press, e_rel, e_long});
         else n_pass++;
         if (c <= 30) begin
            if (press[1] && p < 0) p = c;
            n_long += long_press[1];
            if (released[1]) begin n_rel++; rel_at = c; end
            if (p > 0 && c == p + 4) btn_in[1] = 1'b0;
            if (c == 30) btn_in[1] = 1'b1;
         end else begin
            if (press[1] && p2 < 0) p2 = c;
            if (long_press[1] && long2 < 0) long2 = c;
            if (c == 50) btn_in[1] = 1'b0;
         end
      end
      repeat_en = '0;
      n_total++;
      if (n_long != 0 || n_rel != 1 || rel_at - p != LONG)
         $display("FAIL coll_release got=%0d/%0d@%0d want=0/1@%0d",
                  n_long, n_rel, rel_at - p, LONG);
      else n_pass++;
      n_total++;
      if (long2 - p2 != LONG)
         $display("FAIL coll_rehold got=%0d want=%0d", long2 - p2, LONG);
      else n_pass++;
   endtask

   task automatic test_random();
      int left [N_CH];
      for (int i = 0; i < N_CH; i++) left[i] = $urandom_range(1, 20);
      for (int c = 1; c <= 600; c++) begin
         @(posedge clk); #1;
         n_total++;
         if ({level, press, released, long_press} !==
             {e_level, e_press, e_rel, e_long})
            $display("FAIL rand_model c=%0d got=%h want=%h", c,
                     {level, press, released, long_press},
                     {e_level, e_press, e_rel, e_long});
         else n_pass++;
         for (int i = 0; i < N_CH; i++) begin
            left[i]--;
            if (left[i] <= 0) begin
               btn_in[i] = ~btn_in[i];
               left[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4)
                                                     : $urandom_range(5, 30);
            end
         end
         if (c % 16 == 0) repeat_en = 4'($urandom);
         if (c == 300) #2 rst = 1'b0;
         if (c == 302) rst = 1'b1;
      end
      btn_in = '0; repeat_en = '0;
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_long_repeat();
      test_repeat_toggle();
      test_independent();
      test_collision();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
